// File: rtl/sync_fifo_gen2.sv
// ---------------------------------------------------------------------------
// sync_fifo_gen2
//   Parametrised single-clock FIFO for producer/consumer pipeline stages in
//   one clock domain. It supports any depth >= 2, and its pointers wrap by
//   explicit compare. It has programmable almost-full/almost-empty
//   thresholds and an optional first-word-fall-through read port. It also
//   provides a synchronous flush and a high-water-mark (peak) counter.
//
// Parameters
//   DATA_WIDTH : width of data_in / data_out
//   FIFO_DEPTH : number of entries (>= 2)
//   FWFT       : 0 = registered read (latency 1), 1 = first-word-fall-through
//   CW         : width of count / peak / threshold fields (derived)
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, data_in  : write request and data
//   rd_en           : read request (pops the head in FWFT mode)
//   flush           : synchronous clear of contents, pointers and peak
//   af_thresh       : almost_full  = count >= af_thresh
//   ae_thresh       : almost_empty = count <= ae_thresh
//   data_out        : read data
//   rd_valid        : data_out holds valid read data
//   full, empty     : occupancy flags from the registered count
//   wr_ack          : write of the previous cycle was accepted
//   overflow        : write of the previous cycle was rejected (full)
//   underflow       : read of the previous cycle was rejected (empty)
//   count           : current occupancy
//   peak            : maximum occupancy since the last reset/flush
// ---------------------------------------------------------------------------
module sync_fifo_gen2 #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         peak
);

    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    // Storage: plain register array, deliberately not reset.
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] peak_q, peak_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_accept;
    logic          rd_accept;

    // Depth need not be a power of two, so the pointer wraps on an explicit
    // compare against the last index instead of relying on bit rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Flags: combinational from the registered count and live thresholds.
    // af_thresh = 0 and ae_thresh >= FIFO_DEPTH fall out of the compares.
    // -----------------------------------------------------------------------
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

    // Flush wins over same-cycle requests, which are dropped silently.
    assign wr_accept = wr_en && !full  && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        peak_d      = peak_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            peak_d   = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_accept) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end

            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // count never exceeds FIFO_DEPTH, so peak saturates there too.
            peak_d = (count_d > peak_q) ? count_d : peak_q;

            wr_ack_d    = wr_accept;
            overflow_d  = wr_en && full;
            underflow_d = rd_en && empty;
        end
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            peak_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            peak_q      <= peak_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write port; reset/flush leave contents untouched.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // Read port
    // -----------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is always presented; rd_en just pops it.
            assign data_out = mem[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        data_out_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign data_out = data_out_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;
    assign peak      = peak_q;

    // Structural invariants
    a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
    a_full_empty  : assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule

// File: tb/tb_sync_fifo_gen2.sv
module tb_sync_fifo_gen2;

    localparam int NI = 3;   // u0: depth16 std, u1: depth6 std, u2: depth16 FWFT

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, rd_en, flush;
    logic [15:0] data_in;
    logic [4:0]  af16, ae16;
    logic [2:0]  af6, ae6;

    logic [15:0] dout [NI];
    logic        rdv [NI], ful [NI], emp [NI], afl [NI], ael [NI];
    logic        ack [NI], ovf [NI], unf [NI];
    logic [4:0]  cnt_a, pk_a, cnt_c, pk_c;
    logic [2:0]  cnt_b, pk_b;

    sync_fifo_gen2 #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .FWFT(0)) u_std16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .af_thresh(af16), .ae_thresh(ae16),
        .data_out(dout[0]), .rd_valid(rdv[0]), .full(ful[0]), .empty(emp[0]),
        .almost_full(afl[0]), .almost_empty(ael[0]), .wr_ack(ack[0]),
        .overflow(ovf[0]), .underflow(unf[0]), .count(cnt_a), .peak(pk_a)
    );

    sync_fifo_gen2 #(.DATA_WIDTH(16), .FIFO_DEPTH(6), .FWFT(0)) u_std6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .af_thresh(af6), .ae_thresh(ae6),
        .data_out(dout[1]), .rd_valid(rdv[1]), .full(ful[1]), .empty(emp[1]),
        .almost_full(afl[1]), .almost_empty(ael[1]), .wr_ack(ack[1]),
        .overflow(ovf[1]), .underflow(unf[1]), .count(cnt_b), .peak(pk_b)
    );

    sync_fifo_gen2 #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .FWFT(1)) u_fwft16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .af_thresh(af16), .ae_thresh(ae16),
        .data_out(dout[2]), .rd_valid(rdv[2]), .full(ful[2]), .empty(emp[2]),
        .almost_full(afl[2]), .almost_empty(ael[2]), .wr_ack(ack[2]),
        .overflow(ovf[2]), .underflow(unf[2]), .count(cnt_c), .peak(pk_c)
    );

    // ---------------- reference model (queue per FIFO) ----------------
    int unsigned dep     [NI] = '{16, 6, 16};
    bit          is_fwft [NI] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mq   [NI][$];    // modelled contents, head at index 0
    logic [15:0] sb   [NI][$];    // scoreboard: expected read data (std mode)
    logic [15:0] held [NI];       // value data_out should hold between reads
    int unsigned mpk  [NI];
    bit          e_ack [NI], e_ovf [NI], e_unf [NI], e_rdv [NI];
    bit          armed;
    int          vec, bad;

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Applies the rules for one clock edge to every modelled FIFO.
    task automatic model_edge(input bit r_s, input bit w, input logic [15:0] d,
                              input bit r, input bit f);
        for (int i = 0; i < NI; i++) begin
            int unsigned n;
            bit          wa, ra;
            logic [15:0] v;
            n = mq[i].size();
            if (r_s) begin
                mq[i].delete();
                sb[i].delete();
                held[i] = '0;
                mpk[i]  = 0;
                e_ack[i] = 0; e_ovf[i] = 0; e_unf[i] = 0; e_rdv[i] = 0;
            end else if (f) begin
                mq[i].delete();
                mpk[i]  = 0;
                e_ack[i] = 0; e_ovf[i] = 0; e_unf[i] = 0; e_rdv[i] = 0;
            end else begin
                wa = w && (n < dep[i]);
                ra = r && (n > 0);
                e_ack[i] = wa;
                e_ovf[i] = w && (n == dep[i]);
                e_unf[i] = r && (n == 0);
                e_rdv[i] = ra;
                if (ra) begin
                    v = mq[i].pop_front();
                    if (!is_fwft[i]) begin
                        sb[i].push_back(v);
                        held[i] = v;
                    end
                end
                if (wa) mq[i].push_back(d);
                if (mq[i].size() > mpk[i]) mpk[i] = mq[i].size();
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_all();
        int c [NI], p [NI], af [NI], ae [NI];
        c[0] = int'(cnt_a); c[1] = int'(cnt_b); c[2] = int'(cnt_c);
        p[0] = int'(pk_a);  p[1] = int'(pk_b);  p[2] = int'(pk_c);
        af[0] = int'(af16); af[1] = int'(af6);  af[2] = int'(af16);
        ae[0] = int'(ae16); ae[1] = int'(ae6);  ae[2] = int'(ae16);
        for (int i = 0; i < NI; i++) begin
            int unsigned n;
            n = mq[i].size();
            chk("count",        i, c[i],   n);
            chk("peak",         i, p[i],   mpk[i]);
            chk("full",         i, ful[i], n == dep[i]);
            chk("empty",        i, emp[i], n == 0);
            chk("almost_full",  i, afl[i], n >= af[i]);
            chk("almost_empty", i, ael[i], n <= ae[i]);
            chk("wr_ack",       i, ack[i], e_ack[i]);
            chk("overflow",     i, ovf[i], e_ovf[i]);
            chk("underflow",    i, unf[i], e_unf[i]);
            if (is_fwft[i]) begin
                chk("rd_valid", i, rdv[i], n != 0);
                if (rdv[i] && n != 0) chk("fwft_head", i, dout[i], mq[i][0]);
            end else begin
                chk("rd_valid", i, rdv[i], e_rdv[i]);
                if (rdv[i]) begin
                    if (sb[i].size() == 0) chk("sb_underrun", i, 1, 0);
                    else chk("data_out", i, dout[i], sb[i].pop_front());
                end else begin
                    chk("data_hold", i, dout[i], held[i]);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (armed) check_all();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r_s, input bit w, input logic [15:0] d,
                       input bit r, input bit f);
        rst = r_s; wr_en = w; data_in = d; rd_en = r; flush = f;
        @(posedge clk);
        model_edge(r_s, w, d, r, f);
        if (r_s) armed = 1'b1;
        #1;
    endtask

    initial begin
        vec = 0; bad = 0; armed = 1'b0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; data_in = '0;
        af16 = 5'd15; ae16 = 5'd1; af6 = 3'd5; ae6 = 3'd1;

        cyc(1, 0, 16'h0, 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);

        // fill to full plus one rejected write
        for (int k = 1; k <= 17; k++) cyc(0, 1, 16'(k), 0, 0);
        // drain plus one rejected read
        ae16 = 5'd2; ae6 = 3'd2;
        for (int k = 0; k < 17; k++) cyc(0, 0, 16'h0, 1, 0);

        // simultaneous wr/rd at full, at empty, and mid-level
        for (int k = 0; k < 16; k++) cyc(0, 1, 16'h0100 + 16'(k), 0, 0);
        cyc(0, 1, 16'h0BAD, 1, 0);
        for (int k = 0; k < 15; k++) cyc(0, 0, 16'h0, 1, 0);
        cyc(0, 1, 16'h0C00, 1, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 16'h0C10 + 16'(k), 0, 0);
        cyc(0, 1, 16'h0D00, 1, 0);

        // interleaved traffic across pointer wrap
        cyc(0, 0, 16'h0, 0, 1);
        for (int k = 0; k < 20; k++) cyc(0, (k % 3) != 2, 16'h0E00 + 16'(k), (k % 2) == 1, 0);
        for (int k = 0; k < 8; k++) cyc(0, 0, 16'h0, 1, 0);

        // FWFT: write to empty, observe, pop
        cyc(0, 0, 16'h0, 0, 1);
        cyc(0, 1, 16'hABCD, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 1, 0);
        cyc(0, 0, 16'h0, 0, 0);

        // flush at count 7 with concurrent requests
        for (int k = 0; k < 7; k++) cyc(0, 1, 16'h0F00 + 16'(k), 0, 0);
        cyc(0, 1, 16'h0FFF, 1, 1);
        cyc(0, 0, 16'h0, 0, 0);

        // threshold corner values
        af16 = 5'd0; ae16 = 5'd20; af6 = 3'd0; ae6 = 3'd7;
        cyc(0, 1, 16'h1234, 0, 0);
        cyc(0, 0, 16'h0, 1, 0);

        // randomized traffic in write-heavy / read-heavy / balanced phases
        for (int k = 0; k < 1500; k++) begin
            int unsigned wp, rp;
            unique case ((k / 100) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 55; rp = 55; end
            endcase
            if ($urandom_range(0, 15) == 0) begin
                af16 = 5'($urandom); ae16 = 5'($urandom);
                af6  = 3'($urandom); ae6  = 3'($urandom);
            end
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 99) < wp,
                16'($urandom),
                $urandom_range(0, 99) < rp,
                $urandom_range(0, 49) == 0);
        end
        cyc(0, 0, 16'h0, 0, 0);

        @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("sb_leftover", i, sb[i].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's fixed-size FIFO.
- Generalises data width and depth.
- Adds runtime-programmable almost-full/almost-empty thresholds.
- Adds a first-word-fall-through (FWFT) read mode, a synchronous flush and a high-water-mark counter.
- Sits between producer and consumer pipeline stages in the same clock domain; it keeps the existing wr_ack/overflow/underflow handshake semantics.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out
FIFO_DEPTH, 16, number of entries; any integer >= 2 (not restricted to powers of two)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CW, $clog2(FIFO_DEPTH+1), width of count/threshold/peak fields (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop in FWFT mode)
flush  input  1  synchronous clear of contents, one-cycle pulse
af_thresh  input  CW  almost_full threshold
ae_thresh  input  CW  almost_empty threshold
data_out  output  DATA_WIDTH  read data
rd_valid  output  1  data_out holds valid read data
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write rejected (full)
underflow  output  1  previous-cycle read rejected (empty)
count  output  CW  current occupancy
peak  output  CW  max occupancy since last reset/flush

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, peak=0, data_out=0, rd_valid=0, wr_ack=0, overflow=0, underflow=0. Reset overrides every other input.
- Flag outputs are combinational from the registered count and the threshold inputs, so empty=1, full=0 while in reset; almost_empty/almost_full follow the thresholds.
- Write accept: wr_en && !full, where full is the registered value at that edge. On accept, mem[wr_ptr]<=data_in and wr_ptr advances.
- Read accept: rd_en && !empty, same rule. On accept, rd_ptr advances.
- Pointer wrap: a pointer at FIFO_DEPTH-1 wraps to 0. Explicit compare is required; power-of-two rollover is not used.
- Count update: +1 on write-only accept, -1 on read-only accept, unchanged when both are accepted or neither.
- wr_ack/overflow/underflow are registered and appear exactly one cycle after the request:
  - wr_ack <= write accepted.
  - overflow <= wr_en && full.
  - underflow <= rd_en && empty.
- Simultaneous wr_en && rd_en:
  - When full: read accepted, write rejected (overflow=1, count -> FIFO_DEPTH-1).
  - When empty: write accepted, read rejected (underflow=1, count -> 1).
  - Otherwise both are accepted and count is unchanged.
- Standard mode (FWFT=0):
  - Accepted read: data_out <= mem[rd_ptr] and rd_valid=1 for one cycle; read latency is 1.
  - Otherwise data_out holds its value and rd_valid=0.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en pops the head entry.
  - A write to an empty FIFO is visible on data_out the cycle after the write.
- Flush (flush=1, rst=0):
  - Pointers, count and peak go to 0; wr_ack/overflow/underflow go to 0 next cycle.
  - Flush has priority over a same-cycle wr_en/rd_en; those requests are dropped without a flag.
  - Standard mode: data_out holds and rd_valid goes to 0.
  - Memory contents are not cleared.
- peak: peak <= max(peak, next_count) every cycle; it saturates at FIFO_DEPTH.
- Thresholds:
  - Sampled continuously; they may change at any time and take effect combinationally.
  - af_thresh=0 forces almost_full=1.
  - ae_thresh >= FIFO_DEPTH forces almost_empty=1.
  - Out-of-range values need no special handling.
- Invariants: count <= FIFO_DEPTH, and never full && empty.
- Memory: plain register array, no reset on memory storage.

Test Plan:
- rst=1 for 2 cycles, ae=1, af=15 -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, all pulse outputs 0, data_out=0.
- DEPTH=16, FWFT=0: write 16 words 0x0001..0x0010, then 1 extra write:
  - wr_ack=1 for 16 cycles, each one cycle after its write; full=1 at count=16.
  - Extra write -> overflow=1 next cycle, count stays 16, peak=16.
- From full: read 16 words -> data_out 0x0001..0x0010 each 1 cycle after rd_en, rd_valid pulses.
  - One more read -> underflow=1; empty=1; almost_empty asserts at count<=ae_thresh (ae=2 -> count 2).
- Simultaneous wr/rd at count=16 -> overflow=1, count=15.
  - At count=0 -> underflow=1, count=1.
  - At count=5 -> wr_ack=1, count=5.
- Wrap-around with DEPTH=6, 20 interleaved write/read cycles -> data_out ordering matches the write order across wrap.
- FWFT=1:
  - Write 0xABCD to empty -> next cycle data_out=0xABCD, rd_valid=1; rd_en -> empty=1, rd_valid=0.
  - Flush at count=7 with concurrent wr_en -> count=0, peak=0, wr_ack=0, overflow=0.
